// File: rtl/mem_rd_stream.sv
// Burst read sequencer for mem_dp port B: fetches len words from base and
// re-times them through a 2-entry FIFO onto a valid/ready stream.
module mem_rd_stream #(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic [AWIDTH-1:0] base,
    input  logic [AWIDTH-1:0] len,
    output logic              busy,
    output logic              done,
    output logic              mem_en,
    output logic [AWIDTH-1:0] mem_addr,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_last
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic [AWIDTH-1:0]   addr_r;
    logic [AWIDTH-1:0]   len_r;
    logic [AWIDTH-1:0]   issued_r;
    logic                done_r;

    logic                inflight_r;
    logic                inflight_last_r;

    logic [DWIDTH-1:0]   fifo_data_r [2];
    logic                fifo_last_r [2];
    logic                wr_ptr_r;
    logic                rd_ptr_r;
    logic [1:0]          cnt_r;

    logic                pop_s;
    logic [2:0]          occ_s;
    logic                issue_s;
    logic                issue_last_s;
    logic                last_pop_s;
    logic                head_valid_s;

    // Handshake and occupancy terms shared by the FSM and the datapath
    always_comb begin
        head_valid_s = (cnt_r != 2'd0);
        pop_s        = head_valid_s & out_ready;
        occ_s        = {1'b0, cnt_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_last_s = (issued_r == (len_r - AWIDTH'(1)));
        last_pop_s   = pop_s & fifo_last_r[rd_ptr_r];
        // A read may only be issued when its word is guaranteed a FIFO slot
        if ((state_r == S_RUN) && (occ_s < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (req && (len != {AWIDTH{1'b0}})) begin
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (issue_s && issue_last_s) begin
                    state_nxt_s = S_DRAIN;
                end else begin
                    state_nxt_s = S_RUN;
                end
            end
            S_DRAIN: begin
                if (last_pop_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    state_nxt_s = S_DRAIN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Burst bookkeeping: captured parameters, read address, issue count, done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_r   <= {AWIDTH{1'b0}};
            len_r    <= {AWIDTH{1'b0}};
            issued_r <= {AWIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if ((state_r == S_IDLE) && req) begin
                addr_r   <= base;
                len_r    <= len;
                issued_r <= {AWIDTH{1'b0}};
                done_r   <= (len == {AWIDTH{1'b0}});
            end else if (issue_s) begin
                addr_r   <= addr_r + AWIDTH'(1);
                issued_r <= issued_r + AWIDTH'(1);
            end else if ((state_r == S_DRAIN) && last_pop_s) begin
                done_r <= 1'b1;
            end
        end
    end

    // Read-latency tracker: marks the cycle in which mem_rdata carries a word
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_r      <= 1'b0;
            inflight_last_r <= 1'b0;
        end else begin
            inflight_r      <= issue_s;
            inflight_last_r <= issue_s & issue_last_s;
        end
    end

    // Two-entry output FIFO; push and pop in the same cycle are both honoured
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data_r[0] <= {DWIDTH{1'b0}};
            fifo_data_r[1] <= {DWIDTH{1'b0}};
            fifo_last_r[0] <= 1'b0;
            fifo_last_r[1] <= 1'b0;
            wr_ptr_r       <= 1'b0;
            rd_ptr_r       <= 1'b0;
            cnt_r          <= 2'd0;
        end else begin
            if (inflight_r) begin
                fifo_data_r[wr_ptr_r] <= mem_rdata;
                fifo_last_r[wr_ptr_r] <= inflight_last_r;
                wr_ptr_r              <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            cnt_r <= cnt_r + {1'b0, inflight_r} - {1'b0, pop_s};
        end
    end

    assign busy      = (state_r != S_IDLE);
    assign done      = done_r;
    assign mem_en    = issue_s;
    assign mem_addr  = addr_r;
    assign out_valid = head_valid_s;
    assign out_data  = fifo_data_r[rd_ptr_r];
    assign out_last  = head_valid_s & fifo_last_r[rd_ptr_r];

endmodule

// File: tb/tb_mem_rd_stream.sv
// Self-checking bench for mem_rd_stream: table of bursts, a reset-abort
// sequence and a long random-backpressure run against a RAM/queue model.
module tb_mem_rd_stream;
    localparam int DW = 16;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic [AW-1:0] base;
    logic [AW-1:0] len;
    logic          busy;
    logic          done;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_rdata;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;

    always #5 clk = ~clk;

    mem_rd_stream #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst), .req(req), .base(base), .len(len),
        .busy(busy), .done(done), .mem_en(mem_en), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last)
    );

    // RAM contents: low half holds its address, high half tags bits 15:14
    function automatic logic [DW-1:0] ram_val(input logic [AW-1:0] a);
        if (a[AW-1]) return {6'b110000, a};
        else         return {6'b000000, a};
    endfunction

    initial mem_rdata = 16'h0000;
    always @(posedge clk) if (mem_en) mem_rdata <= ram_val(mem_addr);

    typedef struct { logic [DW-1:0] data; logic last; } word_t;
    typedef struct { logic [AW-1:0] b; logic [AW-1:0] l; int mode; int lat; int inj; } vec_t;

    word_t         exp_q[$];
    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] exp_addr;
    int            n_issue = 0;
    int            n_pop = 0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic          s_done, s_busy, s_valid;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic ready_for(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return (k % 3) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return (k % 2) == 0;
        endcase
    endfunction

    // One clock cycle: sample at negedge, run the monitor, return at posedge+1
    task automatic cycle();
        word_t w;
        @(negedge clk);
        s_done  = done;
        s_busy  = busy;
        s_valid = out_valid;
        chk("occupancy_le_2", ((n_issue - n_pop) <= 2), 32'd1);
        if (mem_en) begin
            chk("mem_addr", {22'd0, mem_addr}, {22'd0, exp_addr});
            exp_addr = exp_addr + 10'd1;
            n_issue++;
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_data", {16'd0, out_data}, {16'd0, prev_data});
            chk("stall_last", {31'd0, out_last}, {31'd0, prev_last});
        end
        if (out_valid && out_ready) begin
            chk("word_expected", (exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                w = exp_q.pop_front();
                chk("out_data", {16'd0, out_data}, {16'd0, w.data});
                chk("out_last", {31'd0, out_last}, {31'd0, w.last});
            end
            n_pop++;
        end
        prev_stall = out_valid & ~out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        @(negedge clk);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_done"}, {31'd0, done}, 32'd0);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, {22'd0, mem_addr}, 32'd0);
        chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
        chk({tag, "_out_data"}, {16'd0, out_data}, 32'd0);
        chk({tag, "_out_last"}, {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic run_burst(input logic [AW-1:0] b, input logic [AW-1:0] l,
                             input int mode, input int exp_lat, input int inj);
        int   k;
        int   budget;
        int   si, sp;
        logic seen;
        logic [AW-1:0] a;
        for (int i = 0; i < int'(l); i++) begin
            a = b + AW'(i);
            exp_q.push_back('{data: ram_val(a), last: (i == int'(l) - 1)});
        end
        exp_addr  = b;
        si        = n_issue;
        sp        = n_pop;
        req       = 1'b1;
        base      = b;
        len       = l;
        out_ready = ready_for(mode, 0);
        cycle();
        chk("done_low_at_req", {31'd0, s_done}, 32'd0);
        chk("busy_low_at_req", {31'd0, s_busy}, 32'd0);
        req    = 1'b0;
        base   = ~b;
        len    = l + 10'd5;
        k      = 1;
        seen   = 1'b0;
        budget = 4 * int'(l) + 40;
        while (!seen && k < budget) begin
            if (k == inj) begin
                req  = 1'b1;
                base = 10'h300;
                len  = 10'd2;
            end else begin
                req = 1'b0;
            end
            out_ready = ready_for(mode, k);
            cycle();
            if (s_done) seen = 1'b1;
            else if (l != 10'd0) chk("busy_in_burst", {31'd0, s_busy}, 32'd1);
            k++;
        end
        req = 1'b0;
        chk("done_seen", {31'd0, seen}, 32'd1);
        if (exp_lat > 0) chk("done_latency", k - 1, exp_lat);
        chk("busy_at_done", {31'd0, s_busy}, 32'd0);
        chk("valid_at_done", {31'd0, s_valid}, 32'd0);
        chk("issued_count", n_issue - si, {22'd0, l});
        chk("delivered_count", n_pop - sp, {22'd0, l});
        chk("queue_empty", exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    vec_t vecs[8];

    initial begin
        int total;
        int k;
        int sp;
        rst = 1'b1; req = 1'b0; base = 10'd0; len = 10'd0; out_ready = 1'b0;
        vecs[0] = '{b: 10'h010, l: 10'd4,  mode: 0, lat: 7,  inj: -1};
        vecs[1] = '{b: 10'h010, l: 10'd4,  mode: 1, lat: -1, inj: -1};
        vecs[2] = '{b: 10'h3FE, l: 10'd4,  mode: 0, lat: 7,  inj: -1};
        vecs[3] = '{b: 10'h000, l: 10'd0,  mode: 0, lat: 1,  inj: -1};
        vecs[4] = '{b: 10'h050, l: 10'd6,  mode: 0, lat: 9,  inj: 2};
        vecs[5] = '{b: 10'h1F0, l: 10'd1,  mode: 0, lat: 4,  inj: -1};
        vecs[6] = '{b: 10'h3FF, l: 10'd3,  mode: 3, lat: -1, inj: -1};
        vecs[7] = '{b: 10'h200, l: 10'd12, mode: 0, lat: 15, inj: -1};

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        for (int v = 0; v < 8; v++)
            run_burst(vecs[v].b, vecs[v].l, vecs[v].mode, vecs[v].lat, vecs[v].inj);

        // Reset after two of eight words, then a fresh short burst
        for (int i = 0; i < 8; i++)
            exp_q.push_back('{data: ram_val(10'h040 + 10'(i)), last: (i == 7)});
        exp_addr = 10'h040;
        sp = n_pop;
        req = 1'b1; base = 10'h040; len = 10'd8; out_ready = 1'b1;
        cycle();
        req = 1'b0;
        k = 0;
        while ((n_pop - sp) < 2 && k < 20) begin
            cycle();
            k++;
        end
        chk("two_words_before_reset", n_pop - sp, 32'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        exp_q.delete();
        n_issue = 0;
        n_pop = 0;
        prev_stall = 1'b0;
        check_zero("after_abort");
        run_burst(10'h100, 10'd2, 0, 5, -1);

        // Back-to-back random bursts under random backpressure
        total = 0;
        while (total < 1000) begin
            int l;
            l = $urandom_range(1, 48);
            run_burst(10'($urandom_range(0, 1023)), 10'(l), 2, -1, -1);
            total += l;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
